// File: rtl/sensor_cfg_pkg.sv
// rtl/sensor_cfg_pkg.sv - register table types and the D5M power-on configuration table
package sensor_cfg_pkg;

    typedef enum logic [1:0] {
        KIND_WRITE = 2'd0,
        KIND_DELAY = 2'd1,
        KIND_END   = 2'd2
    } cfg_kind_e;

    typedef struct packed {
        cfg_kind_e   kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } cfg_entry_t;

    localparam int CFG_DEPTH = 12;

    // Entry i of the table lives at element [i]
    typedef cfg_entry_t [CFG_DEPTH-1:0] cfg_table_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWRUP    = 4'd1,
        ST_LOAD     = 4'd2,
        ST_ISSUE    = 4'd3,
        ST_WAIT_RSP = 4'd4,
        ST_GAP      = 4'd5,
        ST_DELAY    = 4'd6,
        ST_DONE     = 4'd7,
        ST_FAIL     = 4'd8
    } seq_state_e;

    function automatic cfg_entry_t mk_entry(input cfg_kind_e kind, input logic [7:0] addr,
                                            input logic [15:0] data);
        cfg_entry_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    // Unused tail slots are END so a short table terminates cleanly
    function automatic cfg_table_t d5m_table();
        cfg_table_t t;
        for (int i = 0; i < CFG_DEPTH; i++) begin
            t[i] = mk_entry(KIND_END, 8'h00, 16'h0000);
        end
        t[0]  = mk_entry(KIND_WRITE, 8'h0D, 16'h0001); // assert soft reset
        t[1]  = mk_entry(KIND_DELAY, 8'h00, 16'h0000); // let the core settle
        t[2]  = mk_entry(KIND_WRITE, 8'h0D, 16'h0000); // release soft reset
        t[3]  = mk_entry(KIND_WRITE, 8'h09, 16'h0400); // shutter width (exposure)
        t[4]  = mk_entry(KIND_WRITE, 8'h2B, 16'h0013); // green1 gain
        t[5]  = mk_entry(KIND_WRITE, 8'h2C, 16'h0019); // blue gain
        t[6]  = mk_entry(KIND_WRITE, 8'h2D, 16'h0019); // red gain
        t[7]  = mk_entry(KIND_WRITE, 8'h2E, 16'h0013); // green2 gain
        t[8]  = mk_entry(KIND_WRITE, 8'h1E, 16'h4006); // read mode 1
        t[9]  = mk_entry(KIND_WRITE, 8'h20, 16'hC000); // read mode 2 (mirroring)
        t[10] = mk_entry(KIND_END,   8'h00, 16'h0000);
        return t;
    endfunction

    localparam cfg_table_t CFG_TABLE = d5m_table();

endpackage

// File: rtl/sensor_cfg_sequencer.sv
// rtl/sensor_cfg_sequencer.sv - walks the register table and issues I2C register writes with retry
module sensor_cfg_sequencer
    import sensor_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR   = 8'hBA,
    parameter int         POWERUP_CC = 50000,
    parameter int         GAP_CC     = 16,
    parameter int         MAX_RETRY  = 3,
    parameter int         DELAY_CC   = 500000,
    parameter cfg_table_t TABLE      = CFG_TABLE
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset_n,
    input  logic        ul1Start,
    output logic        ul1Busy,
    output logic        ul1Done,
    output logic        ul1Error,
    output logic [7:0]  ul8ErrIndex,
    output logic        ul1Req,
    output logic [7:0]  ul8DevAddr,
    output logic [7:0]  ul8RegAddr,
    output logic [15:0] ul16RegData,
    input  logic        ul1Rsp,
    input  logic        ul1Nack
);

    localparam int CNT_MAX = (POWERUP_CC > DELAY_CC) ? POWERUP_CC : DELAY_CC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Timers count down to zero, so loading N-1 yields exactly N cycles in the state
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_CC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CC - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        index_q, index_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              req_q, req_d;
    logic [7:0]        addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        erridx_q, erridx_d;
    cfg_entry_t        cur_entry;

    // Table lookup; an index past the end reads as END
    always_comb begin
        cur_entry = mk_entry(KIND_END, 8'h00, 16'h0000);
        for (int i = 0; i < CFG_DEPTH; i++) begin
            if (index_q == 8'(i)) begin
                cur_entry = TABLE[i];
            end
        end
    end

    // State register
    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (ul1Start) state_d = ST_PWRUP;
            ST_PWRUP:    if (cnt_q == '0) state_d = ST_LOAD;
            ST_LOAD: begin
                case (cur_entry.kind)
                    KIND_WRITE: state_d = ST_ISSUE;
                    KIND_DELAY: state_d = ST_DELAY;
                    default:    state_d = ST_DONE;
                endcase
            end
            ST_ISSUE:    state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (ul1Rsp) begin
                    if (!ul1Nack || (retry_q < RTY_MAX)) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_GAP:      if (cnt_q == '0) state_d = ST_LOAD;
            ST_DELAY:    if (cnt_q == '0) state_d = ST_LOAD;
            ST_DONE:     state_d = ST_IDLE;
            ST_FAIL:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; flags and Busy change on entry to DONE/FAIL
    always_comb begin
        cnt_d    = cnt_q;
        index_d  = index_q;
        retry_d  = retry_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        erridx_d = erridx_q;
        case (state_q)
            ST_IDLE: begin
                if (ul1Start) begin
                    cnt_d   = PWRUP_LOAD;
                    index_d = 8'd0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_PWRUP, ST_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            ST_LOAD: begin
                case (cur_entry.kind)
                    KIND_WRITE: begin
                        addr_d = cur_entry.addr;
                        data_d = cur_entry.data;
                    end
                    KIND_DELAY: cnt_d = DELAY_LOAD;
                    default: begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                endcase
            end
            ST_ISSUE: req_d = 1'b1;
            ST_WAIT_RSP: begin
                if (ul1Rsp) begin
                    req_d = 1'b0;
                    cnt_d = GAP_LOAD;
                    if (!ul1Nack) begin
                        index_d = index_q + 8'd1;
                        retry_d = '0;
                    end else if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        erridx_d = index_q;
                        busy_d   = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    index_d = index_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset_n) begin
            cnt_q    <= '0;
            index_q  <= 8'd0;
            retry_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= 8'd0;
            data_q   <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            erridx_q <= 8'd0;
        end else begin
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            retry_q  <= retry_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            erridx_q <= erridx_d;
        end
    end

    assign ul1Busy     = busy_q;
    assign ul1Done     = done_q;
    assign ul1Error    = err_q;
    assign ul8ErrIndex = erridx_q;
    assign ul1Req      = req_q;
    assign ul8DevAddr  = DEV_ADDR;
    assign ul8RegAddr  = addr_q;
    assign ul16RegData = data_q;

endmodule

// File: tb/tb_sensor_cfg_sequencer.sv
// tb/tb_sensor_cfg_sequencer.sv - scoreboard bench for sensor_cfg_sequencer
module tb_sensor_cfg_sequencer;
    import sensor_cfg_pkg::*;

    localparam int POWERUP_CC = 20;
    localparam int GAP_CC     = 16;
    localparam int MAX_RETRY  = 3;
    localparam int DELAY_CC   = 100;
    localparam int LIMIT      = 20000;

    function automatic cfg_table_t tb_table();
        cfg_table_t t;
        for (int i = 0; i < CFG_DEPTH; i++) t[i] = mk_entry(KIND_END, 8'h00, 16'h0000);
        t[0] = mk_entry(KIND_WRITE, 8'h20, 16'hC000);
        t[1] = mk_entry(KIND_WRITE, 8'h09, 16'h0400);
        t[2] = mk_entry(KIND_DELAY, 8'h00, 16'h0000);
        t[3] = mk_entry(KIND_WRITE, 8'h0D, 16'h0001);
        t[4] = mk_entry(KIND_END,   8'h00, 16'h0000);
        return t;
    endfunction

    localparam cfg_table_t TB_TABLE = tb_table();

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, error, req, rsp_r, rsp_s, rsp, nack, resp_en;
    logic [7:0]  erridx, dev, ra;
    logic [15:0] rd;

    assign rsp = rsp_r | rsp_s;

    always #5 clk = ~clk;

    sensor_cfg_sequencer #(
        .DEV_ADDR(8'hBA), .POWERUP_CC(POWERUP_CC), .GAP_CC(GAP_CC),
        .MAX_RETRY(MAX_RETRY), .DELAY_CC(DELAY_CC), .TABLE(TB_TABLE)
    ) dut (
        .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1Start(start), .ul1Busy(busy),
        .ul1Done(done), .ul1Error(error), .ul8ErrIndex(erridx), .ul1Req(req),
        .ul8DevAddr(dev), .ul8RegAddr(ra), .ul16RegData(rd), .ul1Rsp(rsp), .ul1Nack(nack)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    bit   resp_nack_q[$];
    int   nack_plan[CFG_DEPTH];
    bit   m_done, m_err;
    int   m_idx;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        else n_pass++;
    endtask

    // Reference: per table entry, the list of attempts and the Req-low gap before each one
    task automatic model_pass();
        int gap;
        bit nk;
        gap = POWERUP_CC + 2;
        m_done = 1'b1; m_err = 1'b0; m_idx = 0;
        for (int i = 0; i < CFG_DEPTH; i++) begin
            if (TB_TABLE[i].kind == KIND_END) break;
            if (TB_TABLE[i].kind == KIND_DELAY) begin
                gap = gap + DELAY_CC + 1;
                continue;
            end
            for (int a = 0; a <= MAX_RETRY; a++) begin
                nk = (a < nack_plan[i]);
                exp_q.push_back('{TB_TABLE[i].addr, TB_TABLE[i].data, gap});
                resp_nack_q.push_back(nk);
                gap = GAP_CC + 2;
                if (!nk) break;
            end
            if (nack_plan[i] > MAX_RETRY) begin
                m_done = 1'b0; m_err = 1'b1; m_idx = i;
                break;
            end
        end
    endtask

    // Responder: answers each Req after a random latency with the planned ACK/NACK
    initial begin : responder
        int lat;
        bit armed;
        armed = 1'b0; lat = 0; rsp_r = 1'b0; nack = 1'b0;
        forever begin
            @(negedge clk);
            rsp_r = 1'b0; nack = 1'b0;
            if (!resp_en || !rst_n) armed = 1'b0;
            else if (!armed) begin
                if (req) begin armed = 1'b1; lat = $urandom_range(2, 40); end
            end else if (!req) armed = 1'b0;
            else if (lat == 0) begin
                rsp_r = 1'b1; armed = 1'b0;
                nack = (resp_nack_q.size() > 0) ? resp_nack_q.pop_front() : 1'b0;
            end else lat--;
        end
    end

    // Monitor: every rising Req is matched against the head of the expected queue
    initial begin : monitor
        int low_cnt;
        bit prev_req;
        exp_t e;
        low_cnt = 0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low_cnt = 0; prev_req = 1'b0;
            end else begin
                if (req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 32'(ra), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_addr", 32'(ra), 32'(e.addr));
                        chk("req_data", 32'(rd), 32'(e.data));
                        chk("req_gap", 32'(low_cnt), 32'(e.gap));
                    end
                    low_cnt = 0;
                end else if (!busy) low_cnt = 0;
                else if (!req) low_cnt++;
                prev_req = req;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_pass(input bit inject);
        int cyc;
        bit injected;
        model_pass();
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("error_cleared", 32'(error), 32'd0);
        cyc = 0; injected = 1'b0;
        while (busy && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (inject && req && !injected) begin start = 1'b1; injected = 1'b1; end
            else start = 1'b0;
        end
        start = 1'b0;
        chk("pass_timeout", 32'(cyc < LIMIT), 32'd1);
        chk("done_flag", 32'(done), 32'(m_done));
        chk("error_flag", 32'(error), 32'(m_err));
        if (m_err) chk("err_index", 32'(erridx), 32'(m_idx));
        repeat (60) @(negedge clk);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        exp_q.delete();
        resp_nack_q.delete();
    endtask

    task automatic clear_plan();
        for (int i = 0; i < CFG_DEPTH; i++) nack_plan[i] = 0;
    endtask

    initial begin : stimulus
        int cyc;
        int r;
        rst_n = 1'b0; start = 1'b0; rsp_s = 1'b0; resp_en = 1'b1;
        clear_plan();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_erridx", 32'(erridx), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_regaddr", 32'(ra), 32'd0);
        chk("rst_regdata", 32'(rd), 32'd0);
        chk("dev_addr", 32'(dev), 32'hBA);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clear_plan();                     run_pass(1'b1);
        clear_plan(); nack_plan[1] = 2;   run_pass(1'b0);
        clear_plan(); nack_plan[0] = 4;   run_pass(1'b0);
        clear_plan();                     run_pass(1'b1);
        clear_plan(); nack_plan[3] = 4;   run_pass(1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                r = $urandom_range(0, 9);
                nack_plan[i] = (r < 6) ? 0 : r - 5;
            end
            run_pass(p[0]);
        end

        // Reset while a request is outstanding
        clear_plan();
        model_pass();
        pulse_start();
        cyc = 0;
        while (!req && cyc < LIMIT) begin @(negedge clk); cyc++; end
        chk("req_wait_timeout", 32'(cyc < LIMIT), 32'd1);
        resp_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        chk("midrst_erridx", 32'(erridx), 32'd0);
        chk("midrst_regaddr", 32'(ra), 32'd0);
        chk("midrst_regdata", 32'(rd), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        resp_nack_q.delete();
        @(negedge clk); rsp_s = 1'b1;
        @(negedge clk); rsp_s = 1'b0;
        repeat (30) @(negedge clk);
        chk("stray_rsp_req", 32'(req), 32'd0);
        chk("stray_rsp_busy", 32'(busy), 32'd0);
        chk("stray_rsp_done", 32'(done), 32'd0);
        resp_en = 1'b1;
        clear_plan(); run_pass(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
